// File: rtl/sd_seq_check.sv
// Sequence checker for a srdy/drdy stream: tracks a per-tag running count,
// flags sequence mismatches and hold-rule violations, and paces c_drdy from a fixed pattern.
//
// state  | meaning
// UNSYNC | no transfer seen for this tag since reset; next count is adopted
// SYNC   | exp[] holds the count the next transfer of this tag must carry
module sd_seq_check #(
    parameter int                 width    = 8,
    parameter int                 tag_sz   = 1,
    parameter int                 pat_dep  = 8,
    parameter logic [pat_dep-1:0] drdy_pat = {pat_dep{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    output logic             err,
    output logic             proto_err,
    output logic [15:0]      err_count,
    output logic [15:0]      proto_count,
    output logic [31:0]      xfer_count
);

    localparam int count_sz = width - tag_sz;
    localparam int num_tags = 1 << tag_sz;
    localparam int pp_w     = (pat_dep > 1) ? $clog2(pat_dep) : 1;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } sync_e;

    logic [pp_w-1:0]     dpp_q, dpp_d;
    logic                drdy_q, drdy_d;
    sync_e               sync_q [num_tags];
    sync_e               sync_d [num_tags];
    logic [count_sz-1:0] exp_q  [num_tags];
    logic [count_sz-1:0] exp_d  [num_tags];
    logic                err_q, err_d;
    logic                proto_err_q, proto_err_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [15:0]         proto_count_q, proto_count_d;
    logic [31:0]         xfer_count_q, xfer_count_d;
    logic                stall_q, stall_d;
    logic [width-1:0]    hold_data_q, hold_data_d;

    logic                xfer;
    logic [tag_sz-1:0]   tag;
    logic [count_sz-1:0] count;
    logic                hold_viol;

    always_comb begin
        xfer  = c_srdy & drdy_q;
        tag   = c_data[width-1 -: tag_sz];
        count = c_data[count_sz-1:0];

        dpp_d  = (dpp_q == pp_w'(pat_dep - 1)) ? '0 : dpp_q + 1'b1;
        drdy_d = drdy_pat[dpp_q];

        sync_d = sync_q;
        exp_d  = exp_q;
        err_d  = 1'b0;
        if (xfer) begin
            case (sync_q[tag])
                UNSYNC: begin
                    sync_d[tag] = SYNC;
                    exp_d[tag]  = count + count_sz'(1);
                end
                SYNC: begin
                    if (count == exp_q[tag]) begin
                        exp_d[tag] = exp_q[tag] + count_sz'(1);
                    end else begin
                        err_d      = 1'b1;
                        exp_d[tag] = count + count_sz'(1);
                    end
                end
                default: sync_d[tag] = UNSYNC;
            endcase
        end

        // A stalled offer must be repeated unchanged on the next cycle.
        hold_viol   = stall_q & (~c_srdy | (c_data != hold_data_q));
        proto_err_d = hold_viol;
        stall_d     = c_srdy & ~drdy_q;
        hold_data_d = c_data;

        err_count_d   = (err_d && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
        proto_count_d = (hold_viol && proto_count_q != 16'hFFFF) ? proto_count_q + 16'd1
                                                                  : proto_count_q;
        xfer_count_d  = xfer ? xfer_count_q + 32'd1 : xfer_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dpp_q         <= '0;
            drdy_q        <= 1'b0;
            sync_q        <= '{default: UNSYNC};
            exp_q         <= '{default: '0};
            err_q         <= 1'b0;
            proto_err_q   <= 1'b0;
            err_count_q   <= 16'd0;
            proto_count_q <= 16'd0;
            xfer_count_q  <= 32'd0;
            stall_q       <= 1'b0;
            hold_data_q   <= '0;
        end else begin
            dpp_q         <= dpp_d;
            drdy_q        <= drdy_d;
            sync_q        <= sync_d;
            exp_q         <= exp_d;
            err_q         <= err_d;
            proto_err_q   <= proto_err_d;
            err_count_q   <= err_count_d;
            proto_count_q <= proto_count_d;
            xfer_count_q  <= xfer_count_d;
            stall_q       <= stall_d;
            hold_data_q   <= hold_data_d;
        end
    end

    assign c_drdy      = drdy_q;
    assign err         = err_q;
    assign proto_err   = proto_err_q;
    assign err_count   = err_count_q;
    assign proto_count = proto_count_q;
    assign xfer_count  = xfer_count_q;

endmodule

// File: tb/tb_sd_seq_check.sv
// Directed bench for sd_seq_check: a default-pattern instance and an alternating-drdy instance.
module tb_sd_seq_check;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_srdy, b_srdy;
    logic [7:0]  a_data, b_data;
    logic        a_drdy, b_drdy;
    logic        a_err, b_err, a_perr, b_perr;
    logic [15:0] a_ecnt, b_ecnt, a_pcnt, b_pcnt;
    logic [31:0] a_xcnt, b_xcnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sd_seq_check dut_a (
        .clk(clk), .reset(reset), .c_srdy(a_srdy), .c_drdy(a_drdy), .c_data(a_data),
        .err(a_err), .proto_err(a_perr), .err_count(a_ecnt), .proto_count(a_pcnt),
        .xfer_count(a_xcnt)
    );

    sd_seq_check #(.width(8), .tag_sz(1), .pat_dep(8), .drdy_pat(8'b0101_0101)) dut_b (
        .clk(clk), .reset(reset), .c_srdy(b_srdy), .c_drdy(b_drdy), .c_data(b_data),
        .err(b_err), .proto_err(b_perr), .err_count(b_ecnt), .proto_count(b_pcnt),
        .xfer_count(b_xcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d);
        a_srdy = 1'b1;
        a_data = d;
        step();
    endtask

    task automatic reset_all();
        a_srdy = 1'b0;
        b_srdy = 1'b0;
        reset  = 1'b1;
        step();
        step();
        chk("rst_drdy", {31'd0, a_drdy}, 0);
        chk("rst_xcnt", a_xcnt, 0);
        chk("rst_ecnt", {16'd0, a_ecnt}, 0);
        reset = 1'b0;
        step();
        chk("post_rst_drdy", {31'd0, a_drdy}, 1);
    endtask

    initial begin
        reset  = 1'b1;
        a_srdy = 1'b0; a_data = 8'h00;
        b_srdy = 1'b0; b_data = 8'h00;
        step(); step(); step();
        chk("reset_a_drdy", {31'd0, a_drdy}, 0);
        chk("reset_a_err", {30'd0, a_err, a_perr}, 0);
        chk("reset_a_counts", {a_ecnt, a_pcnt} | a_xcnt, 0);
        chk("reset_b_drdy", {31'd0, b_drdy}, 0);
        chk("reset_b_counts", {b_ecnt, b_pcnt} | b_xcnt, 0);

        // Alternating drdy: interval k after reset release has drdy = k odd.
        reset = 1'b0; b_srdy = 1'b1; b_data = 8'h00;        // interval 0, stall
        chk("b_i0_drdy", {31'd0, b_drdy}, 0);
        step();                                              // interval 1, transfer 0x00
        chk("b_i1_drdy", {31'd0, b_drdy}, 1);
        step();                                              // interval 2
        chk("b_i2_drdy", {31'd0, b_drdy}, 0);
        chk("b_i2_xcnt", b_xcnt, 1);
        chk("b_i2_perr", {31'd0, b_perr}, 0);
        b_data = 8'h01;                                      // stalled offer
        step();                                              // interval 3: drop srdy
        b_srdy = 1'b0;
        step();                                              // interval 4
        chk("b_drop_perr", {31'd0, b_perr}, 1);
        chk("b_drop_pcnt", {16'd0, b_pcnt}, 1);
        b_srdy = 1'b1; b_data = 8'h01;
        step();                                              // interval 5, transfer 0x01
        chk("b_i5_perr", {31'd0, b_perr}, 0);
        step();                                              // interval 6
        chk("b_i6_xcnt", b_xcnt, 2);
        b_data = 8'h05;                                      // stalled on wrong word
        step();                                              // interval 7: change to 0x02
        b_data = 8'h02;
        step();                                              // interval 8
        chk("b_chg_perr", {31'd0, b_perr}, 1);
        chk("b_pcnt_2", {16'd0, b_pcnt}, 2);
        chk("b_ecnt_0", {16'd0, b_ecnt}, 0);
        chk("b_err_0", {31'd0, b_err}, 0);
        chk("b_xcnt_3", b_xcnt, 3);
        b_data = 8'h07;                                      // stall, exp is 3
        step();                                              // interval 9
        chk("b_i9_perr", {31'd0, b_perr}, 0);
        b_data = 8'h08;                                      // hold violation and mismatch together
        step();                                              // interval 10
        chk("b_both_err", {31'd0, b_err}, 1);
        chk("b_both_perr", {31'd0, b_perr}, 1);
        chk("b_both_ecnt", {16'd0, b_ecnt}, 1);
        chk("b_both_pcnt", {16'd0, b_pcnt}, 3);
        chk("b_both_xcnt", b_xcnt, 4);
        b_srdy = 1'b0;
        step();
        chk("b_pulse_end", {30'd0, b_err, b_perr}, 0);

        // Instance A has idled with drdy high; restart it cleanly.
        reset_all();
        for (int i = 0; i < 128; i++) begin
            send_a(8'(i));
            chk("seq128_err", {31'd0, a_err}, 0);
        end
        a_srdy = 1'b0;
        step();
        chk("seq128_xcnt", a_xcnt, 128);
        chk("seq128_ecnt", {16'd0, a_ecnt}, 0);

        reset_all();
        send_a(8'h7E); chk("wrap_7e", {31'd0, a_err}, 0);
        send_a(8'h7F); chk("wrap_7f", {31'd0, a_err}, 0);
        send_a(8'h00); chk("wrap_00", {31'd0, a_err}, 0);
        send_a(8'h01); chk("wrap_01", {31'd0, a_err}, 0);
        chk("wrap_ecnt", {16'd0, a_ecnt}, 0);
        chk("wrap_xcnt", a_xcnt, 4);

        reset_all();
        send_a(8'h05); chk("gap_05", {31'd0, a_err}, 0);
        send_a(8'h06); chk("gap_06", {31'd0, a_err}, 0);
        send_a(8'h09); chk("gap_09", {31'd0, a_err}, 1);
        chk("gap_ecnt", {16'd0, a_ecnt}, 1);
        send_a(8'h0A); chk("gap_0a", {31'd0, a_err}, 0);
        a_srdy = 1'b0;
        step();
        chk("gap_ecnt_hold", {16'd0, a_ecnt}, 1);
        chk("gap_idle_err", {31'd0, a_err}, 0);

        reset_all();
        for (int i = 0; i < 10; i++) begin
            send_a(8'(i));
            chk("ilv_t0", {31'd0, a_err}, 0);
            send_a(8'h80 | 8'(i));
            chk("ilv_t1", {31'd0, a_err}, 0);
        end
        a_srdy = 1'b0;
        step();
        chk("ilv_xcnt", a_xcnt, 20);
        chk("ilv_ecnt", {16'd0, a_ecnt}, 0);

        reset_all();
        for (int i = 0; i < 10; i++) send_a(8'(i));
        chk("mid_xcnt_10", a_xcnt, 10);
        a_data = 8'h0A;
        reset  = 1'b1;
        step();
        chk("mid_rst_xcnt", a_xcnt, 0);
        chk("mid_rst_drdy", {31'd0, a_drdy}, 0);
        a_data = 8'h33;
        step();
        chk("mid_rst_xcnt2", a_xcnt, 0);
        chk("mid_rst_cnts", {a_ecnt, a_pcnt}, 0);
        reset = 1'b0;
        step();                                              // 0x33 stalled one cycle
        chk("mid_stall_xcnt", a_xcnt, 0);
        chk("mid_stall_perr", {31'd0, a_perr}, 0);
        send_a(8'h33); chk("mid_33_err", {31'd0, a_err}, 0);
        send_a(8'h34); chk("mid_34_err", {31'd0, a_err}, 0);
        send_a(8'h35); chk("mid_35_err", {31'd0, a_err}, 0);
        a_srdy = 1'b0;
        step();
        chk("mid_xcnt_3", a_xcnt, 3);
        chk("mid_ecnt", {16'd0, a_ecnt}, 0);
        chk("mid_pcnt", {16'd0, a_pcnt}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
